decode_arb_mux: RTL
===================

DECODE_ARB_MUX -- requirements
Module: decode_arb_mux

Interface
REQ-001 Parameter NUM_CH, default 4: number of format-decoder input channels, range 2..8.
REQ-002 Parameter FIFO_DEPTH, default 4: entries per channel FIFO; power of two, at least 2.
REQ-003 Parameter FMT_W, default 25: one-hot instruction format width.
REQ-004 Parameter MAJID_W, default 64: major instruction ID width.
REQ-005 Parameter PAYLOAD_W, default 84: operand body width, holding 4 reg operands plus a 64b imm.
REQ-006 clock_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-007 reset_i, input, 1 bit: asynchronous, active-high reset.
REQ-008 flush_i, input, 1 bit: synchronous pipeline flush.
REQ-009 ch_valid_i, input, NUM_CH bits: per-channel instruction valid.
REQ-010 ch_ready_o, output, NUM_CH bits: per-channel space available.
REQ-011 ch_fmt_i, input, NUM_CH*FMT_W bits: packed per-channel format; channel k occupies slice [k*FMT_W +: FMT_W].
REQ-012 ch_majid_i, input, NUM_CH*MAJID_W bits: packed per-channel major ID, same packing.
REQ-013 ch_payload_i, input, NUM_CH*PAYLOAD_W bits: packed per-channel body, same packing.
REQ-014 valid_o, output, 1 bit: output entry valid.
REQ-015 ready_i, input, 1 bit: downstream accepts the output entry.
REQ-016 fmt_o, output, FMT_W bits: selected entry's format.
REQ-017 majid_o, output, MAJID_W bits: selected entry's major ID.
REQ-018 payload_o, output, PAYLOAD_W bits: selected entry's body.
REQ-019 src_ch_o, output, clog2(NUM_CH) bits: index of the channel that supplied the entry.

Function
REQ-020 Each channel SHALL own a FIFO_DEPTH-entry FIFO with a wrap-around read pointer, write pointer and occupancy count.
REQ-021 ch_ready_o[k] SHALL equal (count_k != FIFO_DEPTH), computed from the registered count only.
  - No same-cycle pop-to-push credit.
REQ-022 Push: channel k pushes when ch_valid_i[k] and ch_ready_o[k] are both high at the clock edge.
REQ-023 Load condition: the output register SHALL load when (!valid_o || ready_i) and at least one FIFO is non-empty.
  - The selected FIFO head is popped in the same edge.
REQ-024 No-load clear: if (!valid_o || ready_i) and all FIFOs are empty, valid_o SHALL go low.
  - fmt_o, majid_o, payload_o and src_ch_o hold their last value.
REQ-025 Hold: while valid_o && !ready_i, all outputs SHALL hold stable.
REQ-026 Latency: an entry accepted at edge E into an empty system SHALL appear with valid_o high after edge E+1.
  - No combinational input-to-output path.
REQ-027 Arbitration (default): round-robin over non-empty FIFOs.
  - Search starts at rr_ptr+1 mod NUM_CH.
  - rr_ptr updates to the granted channel on every load.
REQ-028 Full-throughput: every FIFO SHALL sustain one push per cycle with simultaneous push and pop.
  - count is unchanged in that cycle.
REQ-029 Pointer wrap: FIFO pointers SHALL wrap modulo FIFO_DEPTH with no entry loss or duplication.
REQ-030 Flush: flush_i high at an edge SHALL zero all counts and pointers, clear valid_o and set rr_ptr to NUM_CH-1.
  - Flush overrides any push or load in that edge.

Reset
REQ-031 On reset_i high, asynchronously:
  - all FIFO counts and pointers = 0, so ch_ready_o = all ones;
  - valid_o = 0; fmt_o, majid_o, payload_o, src_ch_o = 0;
  - rr_ptr = NUM_CH-1, so channel 0 wins first.
REQ-032 Reset asserted mid-transfer SHALL discard all buffered entries; FIFO storage contents need not be cleared.

Configuration
REQ-033 Macro DECODE_ARB_MUX_ORDERED_EN.
  - Defined: the arbiter selects the non-empty head with the smallest majID; ties go to the lowest channel index; rr_ptr is unused.
  - Undefined: round-robin per REQ-027.

Verification
REQ-034 Reset, then push ch1 with majID 5 at one edge -> valid_o=1 after the next edge, src_ch_o=1, majid_o=5.
REQ-035 All 4 channels push one entry simultaneously, ready_i=1 (round-robin build) -> src_ch_o sequence 0,1,2,3 on consecutive cycles.
REQ-036 Hold ready_i=0, push 5 entries to ch2 (FIFO_DEPTH=4) -> 1 entry in the output register, ch_ready_o[2]=0 after the 5th accept; raise ready_i -> 5 entries out in order with no loss.
REQ-037 Ordered build, heads ch0 majID 9, ch1 majID 3, ch3 majID 7 -> output order 3, 7, 9.
REQ-038 FIFOs and output hold 3 entries, assert flush_i with ch0 valid -> after the edge valid_o=0, ch_ready_o all 1, the ch0 entry is dropped.
REQ-039 Assert reset_i asynchronously mid-stream while valid_o=1 -> valid_o falls without a clock edge and all FIFOs read empty.

Source files
------------

// File: rtl/decode_arb_mux.sv
// Per-channel FIFOs feeding one registered output through an arbiter.
// Define DECODE_ARB_MUX_ORDERED_EN to select the smallest-majID head instead of round-robin.
module decode_arb_mux #(
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int FMT_W      = 25,
    parameter int MAJID_W    = 64,
    parameter int PAYLOAD_W  = 84
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic                          flush_i,
    input  logic [NUM_CH-1:0]             ch_valid_i,
    output logic [NUM_CH-1:0]             ch_ready_o,
    input  logic [NUM_CH*FMT_W-1:0]       ch_fmt_i,
    input  logic [NUM_CH*MAJID_W-1:0]     ch_majid_i,
    input  logic [NUM_CH*PAYLOAD_W-1:0]   ch_payload_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [FMT_W-1:0]              fmt_o,
    output logic [MAJID_W-1:0]            majid_o,
    output logic [PAYLOAD_W-1:0]          payload_o,
    output logic [$clog2(NUM_CH)-1:0]     src_ch_o
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = FMT_W + MAJID_W + PAYLOAD_W;

    logic [ENT_W-1:0]     r_mem    [NUM_CH][FIFO_DEPTH];
    logic [PTR_W-1:0]     r_rd_ptr [NUM_CH];
    logic [PTR_W-1:0]     r_wr_ptr [NUM_CH];
    logic [CNT_W-1:0]     r_count  [NUM_CH];

    logic                 r_valid;
    logic [FMT_W-1:0]     r_fmt;
    logic [MAJID_W-1:0]   r_majid;
    logic [PAYLOAD_W-1:0] r_payload;
    logic [CH_W-1:0]      r_src;

    logic [NUM_CH-1:0]    w_nonempty;
    logic [NUM_CH-1:0]    w_push;
    logic [NUM_CH-1:0]    w_pop;
    logic [ENT_W-1:0]     w_head   [NUM_CH];
    logic                 w_found;
    logic [CH_W-1:0]      w_grant;
    logic                 w_load;

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            ch_ready_o[k] = (r_count[k] != CNT_W'(FIFO_DEPTH));
            w_nonempty[k] = (r_count[k] != '0);
            w_push[k]     = ch_valid_i[k] && (r_count[k] != CNT_W'(FIFO_DEPTH));
            w_head[k]     = r_mem[k][r_rd_ptr[k]];
        end
    end

`ifdef DECODE_ARB_MUX_ORDERED_EN
    logic [MAJID_W-1:0] w_best;

    // Strict less-than while scanning upward gives ties to the lowest channel.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_best  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_nonempty[k] &&
                (!w_found || (w_head[k][PAYLOAD_W +: MAJID_W] < w_best))) begin
                w_found = 1'b1;
                w_grant = CH_W'(k);
                w_best  = w_head[k][PAYLOAD_W +: MAJID_W];
            end
        end
    end
`else
    logic [CH_W-1:0] r_rr_ptr;
    logic [CH_W:0]   w_sum;
    logic [CH_W-1:0] w_idx;

    // Scan starts one past the last grant, wrapping modulo NUM_CH.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_sum = {1'b0, r_rr_ptr} + (CH_W+1)'(i);
            if (w_sum >= (CH_W+1)'(NUM_CH))
                w_sum = w_sum - (CH_W+1)'(NUM_CH);
            w_idx = w_sum[CH_W-1:0];
            if (!w_found && w_nonempty[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i)
            r_rr_ptr <= CH_W'(NUM_CH - 1);
        else if (flush_i)
            r_rr_ptr <= CH_W'(NUM_CH - 1);
        else if (w_load)
            r_rr_ptr <= w_grant;
    end
`endif

    assign w_load = (!r_valid || ready_i) && w_found;

    always_comb begin
        for (int k = 0; k < NUM_CH; k++)
            w_pop[k] = w_load && (w_grant == CH_W'(k));
    end

    // Storage is data only; occupancy lives in the pointers and counts.
    always_ff @(posedge clock_i) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_push[k])
                r_mem[k][r_wr_ptr[k]] <= {ch_fmt_i[k*FMT_W +: FMT_W],
                                          ch_majid_i[k*MAJID_W +: MAJID_W],
                                          ch_payload_i[k*PAYLOAD_W +: PAYLOAD_W]};
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_rd_ptr[k] <= '0;
                r_wr_ptr[k] <= '0;
                r_count[k]  <= '0;
            end
        end else if (flush_i) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_rd_ptr[k] <= '0;
                r_wr_ptr[k] <= '0;
                r_count[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (w_push[k])
                    r_wr_ptr[k] <= r_wr_ptr[k] + PTR_W'(1);
                if (w_pop[k])
                    r_rd_ptr[k] <= r_rd_ptr[k] + PTR_W'(1);
                case ({w_push[k], w_pop[k]})
                    2'b10:   r_count[k] <= r_count[k] + CNT_W'(1);
                    2'b01:   r_count[k] <= r_count[k] - CNT_W'(1);
                    default: r_count[k] <= r_count[k];
                endcase
            end
        end
    end

    // Output register: data fields hold when nothing is loaded.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_valid   <= 1'b0;
            r_fmt     <= '0;
            r_majid   <= '0;
            r_payload <= '0;
            r_src     <= '0;
        end else if (flush_i) begin
            r_valid   <= 1'b0;
        end else if (!r_valid || ready_i) begin
            if (w_found) begin
                r_valid   <= 1'b1;
                r_fmt     <= w_head[w_grant][MAJID_W+PAYLOAD_W +: FMT_W];
                r_majid   <= w_head[w_grant][PAYLOAD_W +: MAJID_W];
                r_payload <= w_head[w_grant][0 +: PAYLOAD_W];
                r_src     <= w_grant;
            end else begin
                r_valid   <= 1'b0;
            end
        end
    end

    assign valid_o   = r_valid;
    assign fmt_o     = r_fmt;
    assign majid_o   = r_majid;
    assign payload_o = r_payload;
    assign src_ch_o  = r_src;

endmodule
